if_fetch_queue: RTL and testbench

//  Parametrised IF stage: pre-IF PC generator issuing up to MAX_OUT pipelined reads on the sram-like inst port

---
 rtl/if_fetch_queue_pkg.sv | 19 +
 rtl/if_fetch_queue_if.sv | 24 ++
 rtl/if_fetch_queue_fetch_iq.sv | 67 ++++++
 rtl/if_fetch_queue.sv | 86 ++++++++
 tb/tb_if_fetch_queue.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the IF stage: the IF->ID bus layout and the address-error exception code.
package if_fetch_queue_pkg;

   localparam int         FS_TO_DS_BUS_WD = 70;
   localparam logic [4:0] EX_ADEL         = 5'h04;

   // Bus layout {ex, excode, inst, pc}; the field order is the wire order seen by ID.
   typedef struct packed {
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_to_ds_t;

   function automatic logic [31:0] phys_addr(input logic [31:0] va);
      return {3'b000, va[28:0]};
   endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// SRAM-like instruction port shared by the fetch stage (master) and the memory bridge (slave).
interface if_fetch_queue_if;
   // Handshake: an address transfers on a cycle with req && addr_ok; each accepted read returns
   // exactly one data_ok pulse carrying rdata, in issue order, no earlier than the next cycle.
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/if_fetch_queue_fetch_iq.sv
// In-order instruction queue: entries are allocated at issue, filled in issue order, popped at the head.
module fetch_iq
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           alloc,
   input  logic           alloc_ex,
   input  logic [31:0]    alloc_pc,
   input  logic           fill,
   input  logic [31:0]    fill_inst,
   input  logic           pop,
   output fs_to_ds_t      head,
   output logic           head_filled,
   output logic           empty,
   output logic [CW-1:0]  occupancy
);

   fs_to_ds_t        ent [DEPTH];
   logic [DEPTH-1:0] filled;
   logic [PW-1:0]    head_ptr, tail_ptr, fill_ptr;
   logic [CW-1:0]    count;

   // Fills only ever target unfilled entries; once an exception entry is allocated fetch halts,
   // so fill_ptr never needs to skip a pre-filled slot before the next flush.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         fill_ptr <= '0;
         count    <= '0;
         filled   <= '0;
      end else begin
         if (alloc) begin
            filled[tail_ptr] <= alloc_ex;
            tail_ptr         <= tail_ptr + 1'b1;
         end
         if (fill) begin
            filled[fill_ptr] <= 1'b1;
            fill_ptr         <= fill_ptr + 1'b1;
         end
         if (pop) head_ptr <= head_ptr + 1'b1;
         count <= count + CW'(alloc) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) begin
         ent[tail_ptr].ex     <= alloc_ex;
         ent[tail_ptr].excode <= alloc_ex ? EX_ADEL : 5'd0;
         ent[tail_ptr].inst   <= 32'd0;
         ent[tail_ptr].pc     <= alloc_pc;
      end
      if (fill) ent[fill_ptr].inst <= fill_inst;
   end

   assign head        = ent[head_ptr];
   assign empty       = (count == '0);
   assign head_filled = filled[head_ptr];
   assign occupancy   = count;

endmodule

// File: rtl/if_fetch_queue.sv
// IF stage: PC generator and issue gate feeding pipelined instruction reads into an in-order queue for ID.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int          IQ_DEPTH = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   input  logic                       ds_allowin,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   if_fetch_queue_if.master           inst_sram
);

   localparam int            OW        = $clog2(MAX_OUT + 1);
   localparam int            CW        = $clog2(IQ_DEPTH) + 1;
   localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
   localparam logic [CW-1:0] DEPTH_C   = CW'(IQ_DEPTH);

   logic [31:0]   pf_pc;
   logic          halt;
   logic [OW-1:0] outstanding, cancel;
   logic [CW-1:0] occupancy;
   logic          iq_empty, head_filled;
   fs_to_ds_t     head;
   logic          issue_ok, misaligned, hs, misal_alloc, fill, pop;

   always_comb begin
      issue_ok    = !halt && !redirect_valid && (outstanding < MAX_OUT_C) && (occupancy < DEPTH_C);
      misaligned  = (pf_pc[1:0] != 2'b00);
      hs          = issue_ok && !misaligned && inst_sram.addr_ok;
      misal_alloc = issue_ok && misaligned;
      fill        = inst_sram.data_ok && (cancel == '0) && !redirect_valid;
      fs_to_ds_valid = !iq_empty && head_filled && !redirect_valid;
      pop         = fs_to_ds_valid && ds_allowin;
   end

   assign inst_sram.req   = issue_ok && !misaligned;
   assign inst_sram.wr    = 1'b0;
   assign inst_sram.size  = 2'h2;
   assign inst_sram.wstrb = 4'h0;
   assign inst_sram.addr  = phys_addr(pf_pc);
   assign inst_sram.wdata = 32'h0;
   assign fs_to_ds_bus    = head;

   always_ff @(posedge clk) begin
      if (reset) begin
         pf_pc       <= RESET_PC;
         halt        <= 1'b0;
         outstanding <= '0;
         cancel      <= '0;
      end else if (redirect_valid) begin
         pf_pc       <= redirect_pc;
         halt        <= 1'b0;
         outstanding <= outstanding - OW'(inst_sram.data_ok);
         // Every read still in flight is now stale; that count already covers older stale ones.
         cancel      <= outstanding - OW'(inst_sram.data_ok);
      end else begin
         if (hs) pf_pc <= pf_pc + 32'd4;
         if (misal_alloc) halt <= 1'b1;
         outstanding <= outstanding + OW'(hs) - OW'(inst_sram.data_ok);
         if (inst_sram.data_ok && (cancel != '0)) cancel <= cancel - 1'b1;
      end
   end

   fetch_iq #(.DEPTH(IQ_DEPTH)) u_iq (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .alloc      (hs || misal_alloc),
      .alloc_ex   (misal_alloc),
      .alloc_pc   (pf_pc),
      .fill       (fill),
      .fill_inst  (inst_sram.rdata),
      .pop        (pop),
      .head       (head),
      .head_filled(head_filled),
      .empty      (iq_empty),
      .occupancy  (occupancy)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised and directed bench for if_fetch_queue against a queue-based model of the fetch stage.
module tb_if_fetch_queue;
   import if_fetch_queue_pkg::*;

   localparam int          IQ_DEPTH = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ds_allowin = 1'b0;
   logic        fs_to_ds_valid;
   logic [69:0] fs_to_ds_bus;

   if_fetch_queue_if inst_sram();

   if_fetch_queue #(.IQ_DEPTH(IQ_DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .ds_allowin    (ds_allowin),
      .fs_to_ds_valid(fs_to_ds_valid),
      .fs_to_ds_bus  (fs_to_ds_bus),
      .inst_sram     (inst_sram)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        ex;
      logic [31:0] inst;
      bit          filled;
   } ent_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rsp_t;

   ent_t exp_q[$];
   rsp_t sram_q[$];
   int          m_infl, m_stale;
   logic [31:0] m_pc;
   bit          m_halt, m_known;

   int n_vec = 0, n_err = 0, cyc = 0;
   int aok_pct = 100, dok_pct = 100, lat_min = 1, lat_max = 1, allow_pct = 100;
   bit rst_now = 0, redir_now = 0, redir_on_dok = 0, dok_fired = 0;
   logic [31:0] redir_target = 32'h0;
   int dut_hs_cnt, dut_req_cnt, dut_pop_cnt, first_hs, first_val;
   logic [69:0] first_bus;

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic clear_obs();
      dut_hs_cnt = 0; dut_req_cnt = 0; dut_pop_cnt = 0;
      first_hs = -1; first_val = -1; first_bus = '0;
   endtask

   task automatic step();
      bit   exp_valid, can, exp_req;
      ent_t e;
      rsp_t r;
      @(posedge clk);
      #1;
      cyc++;
      reset      = rst_now;
      rst_now    = 0;
      ds_allowin = ($urandom_range(0, 99) < allow_pct);
      inst_sram.addr_ok = ($urandom_range(0, 99) < aok_pct);
      if (sram_q.size() > 0 && cyc >= sram_q[0].due && $urandom_range(0, 99) < dok_pct) begin
         inst_sram.data_ok = 1'b1;
         inst_sram.rdata   = sram_q[0].data;
      end else begin
         inst_sram.data_ok = 1'b0;
         inst_sram.rdata   = $urandom;
      end
      redirect_valid = redir_now || (redir_on_dok && inst_sram.data_ok && m_infl == 2);
      if (redirect_valid && redir_on_dok && !redir_now) dok_fired = 1;
      if (redirect_valid) begin redir_now = 0; redir_on_dok = 0; end
      redirect_pc = redir_target;

      @(negedge clk);
      exp_valid = exp_q.size() > 0 && exp_q[0].filled && !redirect_valid;
      can       = !m_halt && !redirect_valid && m_infl < MAX_OUT && exp_q.size() < IQ_DEPTH;
      exp_req   = can && (m_pc[1:0] == 2'b00);
      if (m_known) begin
         check("req", inst_sram.req, exp_req);
         if (exp_req) check("addr", inst_sram.addr, {3'b000, m_pc[28:0]});
         check("valid", fs_to_ds_valid, exp_valid);
         if (exp_valid)
            check("bus", fs_to_ds_bus, {exp_q[0].ex, exp_q[0].ex ? EX_ADEL : 5'd0, exp_q[0].inst, exp_q[0].pc});
         check("sram_const", {inst_sram.wr, inst_sram.size, inst_sram.wstrb, inst_sram.wdata},
               {1'b0, 2'h2, 4'h0, 32'h0});
      end
      if (!reset) begin
         if (inst_sram.req) dut_req_cnt++;
         if (inst_sram.req && inst_sram.addr_ok) begin
            dut_hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
         end
         if (fs_to_ds_valid && first_val < 0) begin first_val = cyc; first_bus = fs_to_ds_bus; end
         if (fs_to_ds_valid && ds_allowin) dut_pop_cnt++;
      end

      if (reset) begin
         exp_q.delete(); sram_q.delete();
         m_infl = 0; m_stale = 0; m_pc = RESET_PC; m_halt = 0; m_known = 1;
      end else if (m_known) begin
         if (inst_sram.data_ok) void'(sram_q.pop_front());
         if (inst_sram.req && inst_sram.addr_ok) begin
            r.data = $urandom;
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            sram_q.push_back(r);
         end
         if (redirect_valid) begin
            exp_q.delete();
            m_pc    = redirect_pc;
            m_halt  = 0;
            m_infl  = m_infl - int'(inst_sram.data_ok);
            m_stale = m_infl;
         end else begin
            if (exp_valid && ds_allowin) void'(exp_q.pop_front());
            if (inst_sram.data_ok) begin
               m_infl--;
               if (m_stale > 0) m_stale--;
               else begin
                  for (int i = 0; i < exp_q.size(); i++) begin
                     if (!exp_q[i].filled) begin
                        exp_q[i].inst   = inst_sram.rdata;
                        exp_q[i].filled = 1;
                        break;
                     end
                  end
               end
            end
            if (exp_req && inst_sram.addr_ok) begin
               e.pc = m_pc; e.ex = 0; e.inst = 32'h0; e.filled = 0;
               exp_q.push_back(e);
               m_infl++;
               m_pc = m_pc + 32'd4;
            end else if (can && m_pc[1:0] != 2'b00) begin
               e.pc = m_pc; e.ex = 1; e.inst = 32'h0; e.filled = 1;
               exp_q.push_back(e);
               m_halt = 1;
            end
         end
      end
   endtask

   task automatic set_mode(input int aok, input int dok, input int lmin, input int lmax, input int allow);
      aok_pct = aok; dok_pct = dok; lat_min = lmin; lat_max = lmax; allow_pct = allow;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redir_target = pc;
      redir_now    = 1;
      step();
   endtask

   initial begin
      inst_sram.addr_ok = 1'b0;
      inst_sram.data_ok = 1'b0;
      inst_sram.rdata   = 32'h0;

      // Reset release with a zero-wait memory and ID always ready.
      set_mode(100, 100, 1, 1, 100);
      repeat (3) begin rst_now = 1; step(); end
      clear_obs();
      repeat (12) step();
      check("first_latency", 70'(first_val - first_hs), 70'd2);
      check("first_pc", 70'(first_bus[31:0]), 70'(RESET_PC));
      clear_obs();
      repeat (20) step();
      check("throughput", 70'(dut_pop_cnt), 70'd20);

      // ID stalled: the queue fills to its depth and issue stops.
      set_mode(100, 100, 1, 1, 0);
      redirect_to(32'hbfc01000);
      clear_obs();
      repeat (10) step();
      check("stall_reqs", 70'(dut_hs_cnt), 70'(IQ_DEPTH));
      set_mode(100, 100, 1, 1, 100);
      repeat (15) step();

      // Slow memory, redirect with two reads in flight.
      set_mode(100, 100, 3, 3, 100);
      for (int i = 0; i < 20 && m_infl != 2; i++) step();
      check("p3_two_out", 70'(m_infl), 70'd2);
      redirect_to(32'h80001000);
      clear_obs();
      repeat (20) step();
      check("p3_first_pc", 70'(first_bus[31:0]), 70'h80001000);

      // Redirect on the same cycle as a returning read.
      set_mode(100, 100, 2, 2, 100);
      dok_fired = 0; redir_target = 32'h80002000; redir_on_dok = 1;
      for (int i = 0; i < 20 && !dok_fired; i++) step();
      redir_on_dok = 0;
      check("p4_fired", 70'(dok_fired), 70'd1);
      clear_obs();
      repeat (15) step();
      check("p4_first_pc", 70'(first_bus[31:0]), 70'h80002000);

      // Misaligned redirect: one exception entry and fetch halts.
      set_mode(100, 100, 1, 1, 100);
      redirect_to(32'hbfc00002);
      clear_obs();
      repeat (12) step();
      check("p5_no_req", 70'(dut_req_cnt), 70'd0);
      check("p5_ex_bus", first_bus, {1'b1, EX_ADEL, 32'h0, 32'hbfc00002});
      redirect_to(32'hbfc00200);
      repeat (10) step();

      // Reset while the queue is full with two reads outstanding.
      set_mode(100, 100, 4, 4, 0);
      for (int i = 0; i < 40 && !(exp_q.size() == IQ_DEPTH && m_infl == 2); i++) step();
      check("p6_full", 70'({exp_q.size() == IQ_DEPTH, m_infl == 2}), 70'b11);
      rst_now = 1;
      step();
      set_mode(100, 100, 1, 1, 100);
      step();
      check("p6_valid", 70'(fs_to_ds_valid), 70'd0);
      check("p6_req", 70'({inst_sram.req, inst_sram.addr}), 70'({1'b1, 32'h1fc00000}));

      // Random traffic with redirects and occasional resets.
      for (int n = 0; n < 1500; n++) begin
         set_mode($urandom_range(40, 100), $urandom_range(40, 100), 1, $urandom_range(1, 4),
                  $urandom_range(30, 100));
         if ($urandom_range(0, 99) < 3) begin
            redir_target = 32'h80000000 + 32'($urandom_range(0, 4095)) * 4;
            if ($urandom_range(0, 9) == 0) redir_target = redir_target + 32'd2;
            redir_now = 1;
         end else if ($urandom_range(0, 199) == 0) begin
            rst_now = 1;
         end
         step();
      end
      set_mode(100, 100, 1, 1, 100);
      redirect_to(32'hbfc00000);
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
